// File: rtl/bru_pkg.sv
// -----------------------------------------------------------------------------
// bru_pkg
// Shared types and constants for the branch resolve unit.
//   bru_entry_t : one in-flight prediction {pc, hit, taken, pred_next}
//   bru_state_t : resolve FSM states (RUN, SQUASH)
//   PC_STEP     : sequential fetch increment
// -----------------------------------------------------------------------------
package bru_pkg;

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic        hit;
      logic        taken;
      logic [31:0] pred_next;
   } bru_entry_t;

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } bru_state_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// -----------------------------------------------------------------------------
// bru_pred_fifo
// In-order queue of fetch-time predictions.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous clear, dominates push/pop
//   push, wdata   : enqueue request and entry
//   pop           : dequeue request (ignored when empty)
//   rdata         : head entry (valid when !empty)
//   full, empty   : registered full flag, empty decode of the count
// A push while full is accepted only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module bru_pred_fifo
   import bru_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push,
   input  logic       pop,
   input  bru_entry_t wdata,
   output bru_entry_t rdata,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_FW = PTR_W + 1;

   bru_entry_t        mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_FW-1:0] cnt;
   logic [CNT_FW-1:0] cnt_nxt;
   logic              full_r;
   logic              do_push;
   logic              do_pop;

   always_comb begin
      do_pop  = pop && (cnt != '0);
      do_push = push && ((cnt != CNT_FW'(DEPTH)) || do_pop);
      cnt_nxt = cnt;
      if (do_push && !do_pop) begin
         cnt_nxt = cnt + CNT_FW'(1);
      end else if (!do_push && do_pop) begin
         cnt_nxt = cnt - CNT_FW'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         full_r <= 1'b0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         full_r <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         cnt    <= cnt_nxt;
         full_r <= (cnt_nxt == CNT_FW'(DEPTH));
      end
   end

   // Storage carries data only; no reset needed.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = full_r;
   assign empty = (cnt == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Checks fetch-time predictions against EX-stage outcomes, trains the
// predictor, raises a one-cycle redirect on a mispredict and keeps
// saturating performance counters.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   if_valid/if_pc/if_hit/if_taken/if_pred_addr : fetch-time prediction
//   ex_valid/ex_is_branch/ex_taken/ex_target    : oldest instruction resolves
//   q_full                            : prediction queue full, IF must stall
//   upd_addr/upd_target/upd_state_write/upd_state_change/upd_branch
//                                     : one-cycle predictor training pulse
//   redirect/redirect_pc              : one-cycle flush and correct next PC
//   branch_cnt/mispredict_cnt         : saturating event counters
//   err_underflow                     : sticky, resolve seen with empty queue
// -----------------------------------------------------------------------------
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_pc,
   input  logic             if_hit,
   input  logic             if_taken,
   input  logic [31:0]      if_pred_addr,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   output logic             q_full,
   output logic [31:0]      upd_addr,
   output logic [31:0]      upd_target,
   output logic             upd_state_write,
   output logic             upd_state_change,
   output logic             upd_branch,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt,
   output logic             err_underflow
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   bru_state_t       state;
   bru_entry_t       head;
   bru_entry_t       wr_entry;
   logic             fifo_full;
   logic             fifo_empty;
   logic             run;
   logic             push_en;
   logic             pop_en;
   logic             resolve_br;
   logic             is_mispredict;
   logic [31:0]      actual_next;

   logic [31:0]      upd_addr_p1;
   logic [31:0]      upd_target_p1;
   logic             upd_state_write_p1;
   logic             upd_state_change_p1;
   logic             upd_branch_p1;
   logic             redirect_p1;
   logic [31:0]      redirect_pc_p1;
   logic [CNT_W-1:0] branch_cnt_p1;
   logic [CNT_W-1:0] mispredict_cnt_p1;
   logic             err_underflow_r;

   // Stage p0: compare the head prediction with the resolved outcome.
   always_comb begin
      run            = (state == RUN);
      pop_en         = run && ex_valid && !fifo_empty;
      resolve_br     = pop_en && ex_is_branch;
      actual_next    = (ex_is_branch && ex_taken) ? ex_target : head.pc + PC_STEP;
      // A non-branch that aliased onto a taken entry mispredicts here too.
      is_mispredict  = pop_en && (head.pred_next != actual_next);
      // A push in the mispredicting cycle is wrong-path and is discarded.
      push_en        = run && if_valid && !is_mispredict;
      wr_entry.pc        = if_pc;
      wr_entry.hit       = if_hit;
      wr_entry.taken     = if_taken;
      wr_entry.pred_next = (if_hit && if_taken) ? if_pred_addr : if_pc + PC_STEP;
   end

   bru_pred_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (is_mispredict),
      .push  (push_en),
      .pop   (pop_en),
      .wdata (wr_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Stage p1: registered training, redirect and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= RUN;
         upd_addr_p1         <= '0;
         upd_target_p1       <= '0;
         upd_state_write_p1  <= 1'b0;
         upd_state_change_p1 <= 1'b0;
         upd_branch_p1       <= 1'b0;
         redirect_p1         <= 1'b0;
         redirect_pc_p1      <= '0;
         branch_cnt_p1       <= '0;
         mispredict_cnt_p1   <= '0;
         err_underflow_r     <= 1'b0;
      end else begin
         // SQUASH always returns to RUN after its single cycle.
         state               <= is_mispredict ? SQUASH : RUN;
         upd_state_write_p1  <= resolve_br && head.hit;
         upd_branch_p1       <= resolve_br && !head.hit;
         upd_state_change_p1 <= resolve_br && ex_taken;
         upd_addr_p1         <= resolve_br ? head.pc : '0;
         upd_target_p1       <= resolve_br ? ex_target : '0;
         redirect_p1         <= is_mispredict;
         redirect_pc_p1      <= is_mispredict ? actual_next : '0;
         if (resolve_br)    branch_cnt_p1     <= sat_inc(branch_cnt_p1);
         if (is_mispredict) mispredict_cnt_p1 <= sat_inc(mispredict_cnt_p1);
         if (run && ex_valid && fifo_empty) err_underflow_r <= 1'b1;
      end
   end

   // A hit predicting not-taken must have recorded the sequential PC.
   a_pred_consistent : assert property (@(posedge clk) disable iff (rst)
      (pop_en && head.hit && !head.taken) |-> (head.pred_next == head.pc + PC_STEP));

   assign q_full           = fifo_full;
   assign upd_addr         = upd_addr_p1;
   assign upd_target       = upd_target_p1;
   assign upd_state_write  = upd_state_write_p1;
   assign upd_state_change = upd_state_change_p1;
   assign upd_branch       = upd_branch_p1;
   assign redirect         = redirect_p1;
   assign redirect_pc      = redirect_pc_p1;
   assign branch_cnt       = branch_cnt_p1;
   assign mispredict_cnt   = mispredict_cnt_p1;
   assign err_underflow    = err_underflow_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit. A second instance with CNT_W = 2
// shares the stimulus so counter saturation can be observed.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0;
   logic [31:0] if_pc = '0;
   logic        if_hit = 1'b0;
   logic        if_taken = 1'b0;
   logic [31:0] if_pred_addr = '0;
   logic        ex_valid = 1'b0;
   logic        ex_is_branch = 1'b0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;

   logic        q_full, upd_state_write, upd_state_change, upd_branch, redirect, err_underflow;
   logic [31:0] upd_addr, upd_target, redirect_pc, branch_cnt, mispredict_cnt;

   logic        s_q_full, s_upd_state_write, s_upd_state_change, s_upd_branch, s_redirect, s_err_underflow;
   logic [31:0] s_upd_addr, s_upd_target, s_redirect_pc;
   logic [1:0]  s_branch_cnt, s_mispredict_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_hit(if_hit),
      .if_taken(if_taken), .if_pred_addr(if_pred_addr), .ex_valid(ex_valid),
      .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
      .q_full(q_full), .upd_addr(upd_addr), .upd_target(upd_target),
      .upd_state_write(upd_state_write), .upd_state_change(upd_state_change),
      .upd_branch(upd_branch), .redirect(redirect), .redirect_pc(redirect_pc),
      .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt), .err_underflow(err_underflow)
   );

   branch_resolve_unit #(.DEPTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_hit(if_hit),
      .if_taken(if_taken), .if_pred_addr(if_pred_addr), .ex_valid(ex_valid),
      .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
      .q_full(s_q_full), .upd_addr(s_upd_addr), .upd_target(s_upd_target),
      .upd_state_write(s_upd_state_write), .upd_state_change(s_upd_state_change),
      .upd_branch(s_upd_branch), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
      .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt), .err_underflow(s_err_underflow)
   );

   // One clock of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input logic iv, input logic [31:0] pc, input logic h, input logic t,
                      input logic [31:0] pa, input logic ev, input logic eb, input logic et,
                      input logic [31:0] tg);
      if_valid = iv; if_pc = pc; if_hit = h; if_taken = t; if_pred_addr = pa;
      ex_valid = ev; ex_is_branch = eb; ex_taken = et; ex_target = tg;
      @(posedge clk);
      #1;
      if_valid = 1'b0;
      ex_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_valid = 1'b0;
      ex_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL reset.q_full_init got %b exp 0", q_full); end
      checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL reset.branch_cnt_init got %0d exp 0", branch_cnt); end
      for (int i = 0; i < 4; i++) cyc(1, 32'h40 + 32'(i * 4), 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL reset.q_full_traffic got %b exp 1", q_full); end
      cyc(1, 32'h50, 0, 0, 0, 1, 1, 0, 0);
      checks++; if (upd_branch !== 1'b1) begin errors++; $display("FAIL reset.upd_branch_pre got %b exp 1", upd_branch); end
      checks++; if (branch_cnt !== 32'd1) begin errors++; $display("FAIL reset.branch_cnt_pre got %0d exp 1", branch_cnt); end
      rst = 1'b1;
      #1;
      checks++; if (upd_branch !== 1'b0) begin errors++; $display("FAIL reset.upd_branch_async got %b exp 0", upd_branch); end
      checks++; if (upd_addr !== 32'h0) begin errors++; $display("FAIL reset.upd_addr_async got %h exp 0", upd_addr); end
      checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL reset.branch_cnt_async got %0d exp 0", branch_cnt); end
      checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL reset.q_full_async got %b exp 0", q_full); end
      #1;
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL reset.q_full_release got %b exp 0", q_full); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset.err_release got %b exp 0", err_underflow); end
   endtask

   task automatic test_correct_taken();
      do_reset();
      cyc(1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'h200);
      checks++; if (upd_state_write !== 1'b1) begin errors++; $display("FAIL taken.state_write got %b exp 1", upd_state_write); end
      checks++; if (upd_state_change !== 1'b1) begin errors++; $display("FAIL taken.state_change got %b exp 1", upd_state_change); end
      checks++; if (upd_branch !== 1'b0) begin errors++; $display("FAIL taken.upd_branch got %b exp 0", upd_branch); end
      checks++; if (upd_addr !== 32'h100) begin errors++; $display("FAIL taken.upd_addr got %h exp 100", upd_addr); end
      checks++; if (upd_target !== 32'h200) begin errors++; $display("FAIL taken.upd_target got %h exp 200", upd_target); end
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL taken.redirect got %b exp 0", redirect); end
      checks++; if (branch_cnt !== 32'd1) begin errors++; $display("FAIL taken.branch_cnt got %0d exp 1", branch_cnt); end
      checks++; if (mispredict_cnt !== 32'd0) begin errors++; $display("FAIL taken.mispredict_cnt got %0d exp 0", mispredict_cnt); end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (upd_state_write !== 1'b0) begin errors++; $display("FAIL taken.pulse_len got %b exp 0", upd_state_write); end
   endtask

   task automatic test_miss_taken();
      do_reset();
      cyc(1, 32'h104, 0, 0, 32'h0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'h80);
      checks++; if (upd_branch !== 1'b1) begin errors++; $display("FAIL miss.upd_branch got %b exp 1", upd_branch); end
      checks++; if (upd_state_write !== 1'b0) begin errors++; $display("FAIL miss.state_write got %b exp 0", upd_state_write); end
      checks++; if (upd_state_change !== 1'b1) begin errors++; $display("FAIL miss.state_change got %b exp 1", upd_state_change); end
      checks++; if (upd_addr !== 32'h104) begin errors++; $display("FAIL miss.upd_addr got %h exp 104", upd_addr); end
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL miss.redirect got %b exp 1", redirect); end
      checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL miss.redirect_pc got %h exp 80", redirect_pc); end
      checks++; if (mispredict_cnt !== 32'd1) begin errors++; $display("FAIL miss.mispredict_cnt got %0d exp 1", mispredict_cnt); end
      // SQUASH cycle: both a wrong-path push and a resolve must be ignored.
      cyc(1, 32'h500, 1, 1, 32'h999, 1, 0, 0, 0);
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL miss.redirect_len got %b exp 0", redirect); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL miss.squash_ex_ignored got %b exp 0", err_underflow); end
      cyc(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL miss.squash_push_dropped got %b exp 0", redirect); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL miss.post_squash_push got %b exp 0", err_underflow); end
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL miss.queue_empty got %b exp 1", err_underflow); end
   endtask

   task automatic test_alias();
      do_reset();
      cyc(1, 32'h10, 1, 1, 32'h300, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL alias.redirect got %b exp 1", redirect); end
      checks++; if (redirect_pc !== 32'h14) begin errors++; $display("FAIL alias.redirect_pc got %h exp 14", redirect_pc); end
      checks++; if ({upd_state_write, upd_state_change, upd_branch} !== 3'b000) begin errors++; $display("FAIL alias.upd_pulse got %b exp 000", {upd_state_write, upd_state_change, upd_branch}); end
      checks++; if (upd_addr !== 32'h0) begin errors++; $display("FAIL alias.upd_addr got %h exp 0", upd_addr); end
      checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL alias.branch_cnt got %0d exp 0", branch_cnt); end
      checks++; if (mispredict_cnt !== 32'd1) begin errors++; $display("FAIL alias.mispredict_cnt got %0d exp 1", mispredict_cnt); end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_full();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h2000; exp_pc[1] = 32'h3000; exp_pc[2] = 32'h4000; exp_pc[3] = 32'h6000;
      do_reset();
      cyc(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 32'h2000, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL full.q_full_at3 got %b exp 0", q_full); end
      cyc(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full.q_full_at4 got %b exp 1", q_full); end
      cyc(1, 32'h5000, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full.q_full_drop got %b exp 1", q_full); end
      cyc(1, 32'h6000, 0, 0, 0, 1, 1, 0, 0);
      checks++; if (upd_addr !== 32'h1000) begin errors++; $display("FAIL full.first_pop got %h exp 1000", upd_addr); end
      checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full.push_pop_full got %b exp 1", q_full); end
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL full.redirect got %b exp 0", redirect); end
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 0, 1, 1, 0, 0);
         checks++; if (upd_addr !== exp_pc[i]) begin errors++; $display("FAIL full.order%0d got %h exp %h", i, upd_addr, exp_pc[i]); end
      end
      checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL full.q_full_drained got %b exp 0", q_full); end
      checks++; if (branch_cnt !== 32'd5) begin errors++; $display("FAIL full.branch_cnt got %0d exp 5", branch_cnt); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL full.err_early got %b exp 0", err_underflow); end
   endtask

   task automatic test_underflow_sat();
      do_reset();
      cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'h40);
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uflow.err got %b exp 1", err_underflow); end
      checks++; if ({redirect, upd_branch, upd_state_write} !== 3'b000) begin errors++; $display("FAIL uflow.no_pulse got %b exp 000", {redirect, upd_branch, upd_state_write}); end
      checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL uflow.branch_cnt got %0d exp 0", branch_cnt); end
      checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL uflow.q_full got %b exp 0", q_full); end
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 32'(i) << 8, 0, 0, 0, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 1, 1, 1, 32'h40);
         cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      checks++; if (s_mispredict_cnt !== 2'd3) begin errors++; $display("FAIL sat.mispredict_cnt got %0d exp 3", s_mispredict_cnt); end
      checks++; if (s_branch_cnt !== 2'd3) begin errors++; $display("FAIL sat.branch_cnt got %0d exp 3", s_branch_cnt); end
      checks++; if (mispredict_cnt !== 32'd5) begin errors++; $display("FAIL sat.wide_mispredict_cnt got %0d exp 5", mispredict_cnt); end
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL sat.err_sticky got %b exp 1", err_underflow); end
   endtask

   initial begin
      test_reset();
      test_correct_taken();
      test_miss_taken();
      test_alias();
      test_full();
      test_underflow_sat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
